// File: rtl/mips_wb_pkg.sv
// Shared types and constants for the MIPS write-back result selector.
package mips_wb_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int DEF_WIDTH  = 32;
   localparam int DEF_NSRC   = 4;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WAIT = 1'b1
   } wb_state_e;

endpackage

// File: rtl/wb_skid_fifo.sv
// Two-entry in-order result buffer (data + register tag) between the selector and the write port.
module wb_skid_fifo #(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic [TAG_W-1:0]  push_tag,
   input  logic              pop,
   output logic [DATA_W-1:0] head_data,
   output logic [TAG_W-1:0]  head_tag,
   output logic [1:0]        count
);

   logic [DATA_W-1:0] data_mem [2];
   logic [TAG_W-1:0]  tag_mem  [2];
   logic              wr_ptr;
   logic              rd_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         unique case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Storage is data-only; an empty buffer presents zeros instead of stale entries.
   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr] <= push_data;
         tag_mem[wr_ptr]  <= push_tag;
      end
   end

   assign head_data = (count != 2'd0) ? data_mem[rd_ptr] : '0;
   assign head_tag  = (count != 2'd0) ? tag_mem[rd_ptr]  : '0;

endmodule

// File: rtl/mips_wb_select.sv
// Registered write-back result selector with late-source wait and 2-entry output buffer.
// Optional illegal-select checker enabled by defining WBSEL_CHK_EN.
module mips_wb_select
   import mips_wb_pkg::*;
#(
   parameter int              WIDTH     = DEF_WIDTH,
   parameter int              NSRC      = DEF_NSRC,
   parameter int              SELW      = $clog2(NSRC),
   parameter logic [NSRC-1:0] LATE_MASK = NSRC'(4'b0100)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [SELW-1:0]       in_sel,
   input  logic [REG_ADDR_W-1:0] in_dest,
   input  logic [NSRC*WIDTH-1:0] src_data,
   input  logic [NSRC-1:0]       late_done,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic [REG_ADDR_W-1:0] out_dest,
   output logic                  busy,
   output logic                  sel_err
);

   localparam int NPAD = 1 << SELW;

   // Sources padded to the full select range; unused slots read as early, zero data.
   logic [WIDTH-1:0] src_pad [NPAD];
   logic [NPAD-1:0]  late_pad;
   logic [NPAD-1:0]  done_pad;
   logic [NPAD-1:0]  legal_pad;

   for (genvar g = 0; g < NPAD; g++) begin : g_pad
      if (g < NSRC) begin : g_src
         assign src_pad[g]   = src_data[g*WIDTH +: WIDTH];
         assign late_pad[g]  = LATE_MASK[g];
         assign done_pad[g]  = late_done[g];
         assign legal_pad[g] = 1'b1;
      end else begin : g_none
         assign src_pad[g]   = '0;
         assign late_pad[g]  = 1'b0;
         assign done_pad[g]  = 1'b0;
         assign legal_pad[g] = 1'b0;
      end
   end

   wb_state_e             state;
   logic [SELW-1:0]       sel_q;
   logic [REG_ADDR_W-1:0] dest_q;
   logic [1:0]            count;
   logic                  fifo_full;
   logic                  accept;
   logic                  take_late;
   logic                  pop;
   logic                  push_vld_p0;
   logic [WIDTH-1:0]      push_data_p0;
   logic [REG_ADDR_W-1:0] push_dest_p0;

   assign fifo_full = (count == 2'd2);
   assign in_ready  = (state == IDLE) && !fifo_full;
   assign busy      = (state == WAIT);
   assign accept    = in_valid && in_ready;
   assign take_late = accept && late_pad[in_sel] && !done_pad[in_sel];
   assign out_valid = (count != 2'd0);
   assign pop       = out_valid && out_ready;

   // Stage p0: choose what enters the buffer this cycle
   always_comb begin
      push_vld_p0  = 1'b0;
      push_data_p0 = src_pad[in_sel];
      push_dest_p0 = in_dest;
      if (state == WAIT) begin
         push_vld_p0  = done_pad[sel_q] && !fifo_full;
         push_data_p0 = src_pad[sel_q];
         push_dest_p0 = dest_q;
      end else begin
         push_vld_p0  = accept && !take_late;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         unique case (state)
            IDLE:    if (take_late)   state <= WAIT;
            WAIT:    if (push_vld_p0) state <= IDLE;
            default:                  state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (take_late) begin
         sel_q  <= in_sel;
         dest_q <= in_dest;
      end
   end

   // Stage p1: buffered results presented to the register-file write port
   wb_skid_fifo #(
      .DATA_W (WIDTH),
      .TAG_W  (REG_ADDR_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_vld_p0),
      .push_data (push_data_p0),
      .push_tag  (push_dest_p0),
      .pop       (pop),
      .head_data (out_data),
      .head_tag  (out_dest),
      .count     (count)
   );

`ifdef WBSEL_CHK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_err <= 1'b0;
      end else if (accept && !legal_pad[in_sel]) begin
         sel_err <= 1'b1;
      end
   end
`else
   assign sel_err = 1'b0;
`endif

endmodule
